// File: rtl/uart_pkg.sv
// Shared constants for the UART TX arbiter: state codes, defaults, timeout.
// Optional multi-byte lock mode is enabled by defining UART_ARB_LOCK_EN.
package uart_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int WAIT_START_TO  = 4;

  typedef logic [3:0] arb_state_t;

  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_ISSUE  = 4'b0010;
  localparam logic [3:0] ST_WSTART = 4'b0100;
  localparam logic [3:0] ST_WDONE  = 4'b1000;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin winner search: first requester at or above the pointer,
// wrapping at N-1 back to 0.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_index
);

  localparam int IW = $clog2(N);

  always_comb begin
    logic [IW-1:0] v_j;
    o_valid = 1'b0;
    o_index = '0;
    v_j     = '0;
    // Walk from the far end so the closest match to the pointer wins.
    for (int k = N - 1; k >= 0; k--) begin
      v_j = IW'((int'(i_ptr) + k) % N);
      if (i_req[v_j]) begin
        o_valid = 1'b1;
        o_index = v_j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N byte requesters onto one UART transmitter (one-hot FSM).
// Define UART_ARB_LOCK_EN to let a locked requester send back-to-back bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LOCK,
  output logic [NUM_REQ-1:0]            GNT_ACK,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  input  logic                          TX_BUSY,
  output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID,
  output logic                          ARB_BUSY
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [2:0] TO_LAST = 3'(WAIT_START_TO - 1);

  arb_state_t            r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_gid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [2:0]            r_cnt;

  logic                  w_win_valid;
  logic [IW-1:0]         w_win_idx;
  logic                  w_relock;

  uart_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_valid (w_win_valid),
    .o_index (w_win_idx)
  );

`ifdef UART_ARB_LOCK_EN
  assign w_relock = REQ_LOCK[r_gid] & REQ[r_gid];
`else
  logic w_unused_lock;
  assign w_unused_lock = ^REQ_LOCK;
  assign w_relock      = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!TX_BUSY && w_win_valid) begin
            r_gid   <= w_win_idx;
            r_data  <= REQ_DATA[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_ptr   <= (r_gid == IW'(NUM_REQ - 1)) ? '0 : r_gid + IW'(1);
          r_cnt   <= '0;
          r_state <= ST_WSTART;
        end
        ST_WSTART: begin
          // A strobe the transmitter never acknowledges is dropped, not retried.
          if (TX_BUSY) begin
            r_state <= ST_WDONE;
          end else if (r_cnt == TO_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_WDONE: begin
          if (!TX_BUSY) begin
            if (w_relock) begin
              r_data  <= REQ_DATA[r_gid*DATA_WIDTH +: DATA_WIDTH];
              r_state <= ST_ISSUE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign TX_DATA_VALID = (r_state == ST_ISSUE);
  assign TX_P_DATA     = r_data;
  assign GRANT_ID      = r_gid;
  assign ARB_BUSY      = (r_state != ST_IDLE);

  always_comb begin
    GNT_ACK = '0;
    if (TX_DATA_VALID) GNT_ACK[r_gid] = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed vectors, queue-based monitor.
// The lock scenario is exercised when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic [N-1:0]  REQ = '0;
  logic [N-1:0]  REQ_LOCK = '0;
  logic [N*DW-1:0] REQ_DATA = '0;
  logic [N-1:0]  GNT_ACK;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_DATA_VALID;
  logic          TX_BUSY;
  logic [1:0]    GRANT_ID;
  logic          ARB_BUSY;

  logic model_en = 1'b0;
  logic force_busy = 1'b0;
  int   busy_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .REQ           (REQ),
    .REQ_DATA      (REQ_DATA),
    .REQ_LOCK      (REQ_LOCK),
    .GNT_ACK       (GNT_ACK),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .TX_BUSY       (TX_BUSY),
    .GRANT_ID      (GRANT_ID),
    .ARB_BUSY      (ARB_BUSY)
  );

  always #5 CLK = ~CLK;

  // Transmitter model: busy for 10 cycles after each accepted strobe.
  assign TX_BUSY = force_busy | (busy_cnt != 0);
  always @(posedge CLK) begin
    if (model_en && TX_DATA_VALID) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic push(int id, logic [DW-1:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_data(int i, logic [DW-1:0] d);
    REQ_DATA[i*DW +: DW] = d;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (TX_DATA_VALID) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (!ARB_BUSY && !TX_BUSY) return;
    end
    fail_now("wait_idle");
  endtask

  task automatic serve(logic [N-1:0] req, int n, bit hold);
    bit ok;
    REQ = req;
    for (int k = 0; k < n; k++) begin
      wait_valid(ok);
      if (!ok) begin
        fail_now("serve_timeout");
        break;
      end
      if (!hold) REQ = REQ & ~GNT_ACK;
    end
    REQ = '0;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (TX_DATA_VALID) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_issue");
        end else begin
          mon_e = sb.pop_front();
          chk("tx_data", 32'(TX_P_DATA), 32'(mon_e.data));
          chk("grant_id", 32'(GRANT_ID), 32'(mon_e.id));
          chk("gnt_ack", 32'(GNT_ACK), 32'(1) << mon_e.id);
        end
      end else if (GNT_ACK != '0) begin
        chk("stray_ack", 32'(GNT_ACK), 32'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (2) @(negedge CLK);
    chk("rst_valid", 32'(TX_DATA_VALID), 32'(0));
    chk("rst_ack", 32'(GNT_ACK), 32'(0));
    chk("rst_pdata", 32'(TX_P_DATA), 32'(0));
    chk("rst_gid", 32'(GRANT_ID), 32'(0));
    chk("rst_arb_busy", 32'(ARB_BUSY), 32'(0));
    @(negedge CLK);
    RSTn = 1'b1;
    model_en = 1'b1;
    @(negedge CLK);

    // All four requesting: round robin 0,1,2,3,0.
    set_data(0, 8'h11);
    set_data(1, 8'h22);
    set_data(2, 8'h33);
    set_data(3, 8'h44);
    push(0, 8'h11);
    push(1, 8'h22);
    push(2, 8'h33);
    push(3, 8'h44);
    push(0, 8'h11);
    serve(4'b1111, 5, 1'b1);
    wait_idle();

    // Single request: one-cycle latency, payload held after issue.
    set_data(0, 8'hA5);
    push(0, 8'hA5);
    REQ = 4'b0001;
    @(negedge CLK);
    chk("latency", 32'(TX_DATA_VALID), 32'(1));
    REQ = '0;
    set_data(0, 8'hFF);
    wait_idle();
    chk("hold_pdata", 32'(TX_P_DATA), 32'(8'hA5));
    chk("idle_arb_busy", 32'(ARB_BUSY), 32'(0));

    // Transmitter busy in IDLE blocks arbitration.
    force_busy = 1'b1;
    set_data(1, 8'h5C);
    push(1, 8'h5C);
    REQ = 4'b0010;
    repeat (5) begin
      @(negedge CLK);
      chk("busy_block", 32'(TX_DATA_VALID), 32'(0));
    end
    force_busy = 1'b0;
    @(negedge CLK);
    chk("busy_release", 32'(TX_DATA_VALID), 32'(1));
    REQ = '0;
    wait_idle();

    // Transmitter never answers: 4 WAIT_START cycles then IDLE.
    model_en = 1'b0;
    set_data(2, 8'h3C);
    push(2, 8'h3C);
    REQ = 4'b0100;
    @(negedge CLK);
    chk("miss_issue", 32'(TX_DATA_VALID), 32'(1));
    REQ = '0;
    set_data(2, 8'h00);
    repeat (4) begin
      @(negedge CLK);
      chk("wait_start_busy", 32'(ARB_BUSY), 32'(1));
    end
    @(negedge CLK);
    chk("timeout_idle", 32'(ARB_BUSY), 32'(0));
    chk("timeout_pdata", 32'(TX_P_DATA), 32'(8'h3C));
    model_en = 1'b1;

    // Reset while waiting for the transmitter to finish.
    set_data(0, 8'h77);
    push(0, 8'h77);
    serve(4'b0001, 1, 1'b0);
    repeat (3) @(negedge CLK);
    chk("in_wait_done", 32'(ARB_BUSY & TX_BUSY), 32'(1));
    RSTn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(TX_DATA_VALID), 32'(0));
    chk("mid_rst_ack", 32'(GNT_ACK), 32'(0));
    chk("mid_rst_pdata", 32'(TX_P_DATA), 32'(0));
    chk("mid_rst_gid", 32'(GRANT_ID), 32'(0));
    chk("mid_rst_arb_busy", 32'(ARB_BUSY), 32'(0));
    @(negedge CLK);
    RSTn = 1'b1;
    wait_idle();

    // Pointer restarts at 0: requester 0 before requester 2.
    set_data(0, 8'h81);
    set_data(2, 8'h9E);
    push(0, 8'h81);
    push(2, 8'h9E);
    serve(4'b0101, 2, 1'b0);
    wait_idle();

`ifdef UART_ARB_LOCK_EN
    REQ_LOCK = 4'b0001;
    set_data(0, 8'h10);
    set_data(1, 8'h20);
    push(0, 8'h10);
    REQ = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      wait_valid(ok);
      if (!ok) fail_now("lock_timeout");
      if (b < 2) begin
        set_data(0, 8'(8'h11 + b));
        push(0, 8'(8'h11 + b));
      end else begin
        REQ_LOCK = '0;
        REQ = 4'b0010;
        push(1, 8'h20);
      end
    end
    wait_valid(ok);
    if (!ok) fail_now("lock_tail_timeout");
    REQ = '0;
    wait_idle();
`endif

    repeat (2) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the UART payload width.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 RSTn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 REQ  input  NUM_REQ  SHALL carry per-requester send requests; bit i = requester i.
REQ-006 REQ_DATA  input  NUM_REQ*DATA_WIDTH  SHALL carry packed payloads; slice i belongs to requester i.
REQ-007 REQ_LOCK  input  NUM_REQ  SHALL carry per-requester lock hints (used only with UART_ARB_LOCK_EN).
REQ-008 GNT_ACK  output  NUM_REQ  SHALL pulse one cycle on bit i when requester i's byte is issued.
REQ-009 TX_P_DATA  output  DATA_WIDTH  SHALL carry the byte to the UART transmitter.
REQ-010 TX_DATA_VALID  output  1  SHALL be a one-cycle strobe qualifying TX_P_DATA.
REQ-011 TX_BUSY  input  1  SHALL be the transmitter busy flag.
REQ-012 GRANT_ID  output  clog2(NUM_REQ)  SHALL hold the index of the current/last granted requester.
REQ-013 ARB_BUSY  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 FSM SHALL be one-hot with states IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-015 IDLE: with REQ!=0 and TX_BUSY=0, the block SHALL pick the winner round-robin (search from PTR upward, wrap at NUM_REQ-1 to 0), latch its index and data slice, and go to ISSUE.
REQ-016 IDLE with TX_BUSY=1 SHALL not arbitrate; REQ is ignored until TX_BUSY=0.
REQ-017 ISSUE SHALL assert TX_DATA_VALID, GNT_ACK[GRANT_ID] and drive latched data for exactly one cycle, set PTR=(GRANT_ID+1) mod NUM_REQ, then go to WAIT_START.
REQ-018 Latency: REQ sampled in IDLE at edge n SHALL yield TX_DATA_VALID high during cycle n+1.
REQ-019 WAIT_START SHALL advance to WAIT_DONE on TX_BUSY=1; if TX_BUSY stays 0 for 4 cycles it SHALL return to IDLE (transmitter missed strobe; no retry).
REQ-020 WAIT_DONE SHALL return to IDLE on TX_BUSY=0.
REQ-021 Payload SHALL be latched at arbitration; REQ/REQ_DATA changes after latching SHALL not affect the issued byte.
REQ-022 A requester SHALL hold REQ until its GNT_ACK; REQ dropped before arbitration SHALL be cleanly ignored.
REQ-023 Simultaneous requests SHALL each be served within NUM_REQ grants (no starvation).
REQ-024 TX_P_DATA SHALL hold the last issued byte outside ISSUE.

Reset
REQ-025 RSTn low SHALL force IDLE, PTR=0, GRANT_ID=0, latched data=0, TX_P_DATA=0, TX_DATA_VALID=0, GNT_ACK=0, ARB_BUSY=0 immediately.
REQ-026 Reset mid-transfer SHALL discard the latched byte; no GNT_ACK is produced for it.

Configuration
REQ-027 With UART_ARB_LOCK_EN defined: on WAIT_DONE exit, if REQ_LOCK[GRANT_ID] and REQ[GRANT_ID] are high, the block SHALL skip round-robin, relatch the same requester's data and go to ISSUE (multi-byte packet).
REQ-028 Without UART_ARB_LOCK_EN: REQ_LOCK SHALL be unused and every byte SHALL be rearbitrated.

Structure
REQ-029 State encodings, NUM_REQ/DATA_WIDTH defaults and the WAIT_START timeout (4) SHALL live in package uart_pkg.
REQ-030 Winner selection SHALL be a sub-module uart_rr_arbiter (inputs REQ, PTR; outputs valid, index); FSM, latching and PTR stay in uart_tx_arbiter.

Verification
REQ-031 REQ=4'b0001, data0=8'hA5 -> TX_DATA_VALID one cycle later with TX_P_DATA=8'hA5, GNT_ACK=4'b0001, GRANT_ID=0.
REQ-032 REQ=4'b1111 held, TX model busy 10 cycles per byte -> grant order 0,1,2,3,0; exactly one GNT_ACK per issue.
REQ-033 TX_BUSY=1 in IDLE with REQ=4'b0010 -> no TX_DATA_VALID until TX_BUSY falls, then issue within 1 cycle.
REQ-034 TX model never asserts busy -> return to IDLE after 4 WAIT_START cycles, ARB_BUSY=0.
REQ-035 RSTn pulsed low in WAIT_DONE -> all outputs 0 same cycle; next REQ=4'b0100 grants requester 2 (PTR=0 search).
REQ-036 UART_ARB_LOCK_EN, REQ=4'b0011, REQ_LOCK=4'b0001 for 3 bytes -> requester 0 issues 3 consecutive bytes, then requester 1.
